// File: rtl/mc_issue_ctrl_pkg.sv
// Shared definitions for the multi-cycle operator issue controller:
// default widths and latency, latency-counter width, FSM state encoding.
package mc_issue_ctrl_pkg;

    localparam int unsigned MC_DATA_WIDTH  = 32;
    localparam int unsigned DEF_LATENCY    = 2;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    // LATENCY is limited to 1..255, so 8 bits always hold LATENCY-1
    localparam int unsigned LAT_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_LOAD = 2'd1,
        MC_RUN  = 2'd2,
        MC_DONE = 2'd3
    } mc_state_e;

endpackage

// File: rtl/Dummy_mc.sv
// Stand-in multi-cycle operator used around the issue controller.
// On LOAD it latches both operands; each further enabled cycle the result
// rotates through A, A+B, B, A, ... so the sampled value reveals how many
// cycles after LOAD the controller looked at it.
// Ports: CLK_I clock, RST_N_I async active-low reset, EN_I enable,
//        LOAD_I load strobe, OP_A_I/OP_B_I operands, RESULT_O result.
module Dummy_mc #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic                  EN_I,
    input  logic                  LOAD_I,
    input  logic [DATA_WIDTH-1:0] OP_A_I,
    input  logic [DATA_WIDTH-1:0] OP_B_I,
    output logic [DATA_WIDTH-1:0] RESULT_O
);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic [1:0]            r_phase;   // which value the next enabled cycle shows

    // Operand latch and result rotation
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_phase <= 2'd0;
        end else if (EN_I && LOAD_I) begin
            r_a     <= OP_A_I;
            r_b     <= OP_B_I;
            r_res   <= OP_A_I;
            r_phase <= 2'd1;
        end else if (EN_I) begin
            case (r_phase)
                2'd0:    r_res <= r_a;
                2'd1:    r_res <= r_a + r_b;
                default: r_res <= r_b;
            endcase
            r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
        end
    end

    assign RESULT_O = r_res;

endmodule

// File: rtl/mc_issue_ctrl.sv
// Issue controller for a multi-cycle operator: accepts operand pairs,
// strobes them into the MC unit, waits LATENCY cycles, captures the
// result and offers it downstream; counts completed operations.
// Ports: CLK_I/RST_I clock and sync active-high reset;
//        IN_VALID_I/IN_READY_O/OP_A_I/OP_B_I operand handshake;
//        MC_EN_O/MC_LOAD_O/MC_OP_A_O/MC_OP_B_O/MC_RESULT_I MC unit side;
//        OUT_VALID_O/OUT_READY_I/RESULT_O result handshake;
//        OP_CNT_O completed-operation count (wraps).
module mc_issue_ctrl
    import mc_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MC_DATA_WIDTH,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  IN_VALID_I,
    output logic                  IN_READY_O,
    input  logic [DATA_WIDTH-1:0] OP_A_I,
    input  logic [DATA_WIDTH-1:0] OP_B_I,
    output logic                  MC_EN_O,
    output logic                  MC_LOAD_O,
    output logic [DATA_WIDTH-1:0] MC_OP_A_O,
    output logic [DATA_WIDTH-1:0] MC_OP_B_O,
    input  logic [DATA_WIDTH-1:0] MC_RESULT_I,
    output logic                  OUT_VALID_O,
    input  logic                  OUT_READY_I,
    output logic [DATA_WIDTH-1:0] RESULT_O,
    output logic [CNT_WIDTH-1:0]  OP_CNT_O
);

    mc_state_e                r_state;
    mc_state_e                w_state_nxt;
    logic [LAT_CNT_WIDTH-1:0] r_lat_cnt;
    logic [DATA_WIDTH-1:0]    r_op_a;
    logic [DATA_WIDTH-1:0]    r_op_b;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [CNT_WIDTH-1:0]     r_op_cnt;
    logic                     r_mc_en;
    logic                     r_mc_load;
    logic                     r_out_valid;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_handoff;

    // Ready depends only on state, OUT_READY_I and reset, never on IN_VALID_I
    assign w_in_ready = !RST_I &&
                        ((r_state == MC_IDLE) || ((r_state == MC_DONE) && OUT_READY_I));
    assign w_accept   = IN_VALID_I && w_in_ready;

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_handoff   = 1'b0;
        case (r_state)
            MC_IDLE: begin
                if (IN_VALID_I) w_state_nxt = MC_LOAD;
            end
            MC_LOAD: begin
                w_state_nxt = MC_RUN;
            end
            MC_RUN: begin
                if (r_lat_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = MC_DONE;
                end
            end
            MC_DONE: begin
                if (OUT_READY_I) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = IN_VALID_I ? MC_LOAD : MC_IDLE;
                end
            end
            default: w_state_nxt = MC_IDLE;
        endcase
    end

    // State, datapath and registered MC/handshake strobes (decoded from next state)
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= MC_IDLE;
            r_lat_cnt   <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_op_cnt    <= '0;
            r_mc_en     <= 1'b0;
            r_mc_load   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a <= OP_A_I;
                r_op_b <= OP_B_I;
            end
            // Loaded in LOAD so RUN spans exactly LATENCY cycles (LATENCY-1 down to 0)
            if (r_state == MC_LOAD) begin
                r_lat_cnt <= LAT_CNT_WIDTH'(LATENCY - 1);
            end else if ((r_state == MC_RUN) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_CNT_WIDTH'(1);
            end
            if (w_capture) r_result <= MC_RESULT_I;
            if (w_handoff) r_op_cnt <= r_op_cnt + CNT_WIDTH'(1);
            r_mc_en     <= (w_state_nxt == MC_LOAD) || (w_state_nxt == MC_RUN);
            r_mc_load   <= (w_state_nxt == MC_LOAD);
            r_out_valid <= (w_state_nxt == MC_DONE);
        end
    end

    assign IN_READY_O  = w_in_ready;
    assign MC_EN_O     = r_mc_en;
    assign MC_LOAD_O   = r_mc_load;
    assign MC_OP_A_O   = r_op_a;
    assign MC_OP_B_O   = r_op_b;
    assign OUT_VALID_O = r_out_valid;
    assign RESULT_O    = r_result;
    assign OP_CNT_O    = r_op_cnt;

endmodule
